// File: rtl/dof_operand_stage_pkg.sv
// Shared constants and operand-source encoding for the DOF operand stage.
// Optional WB bypass is selected with the DOF_WB_BYPASS_EN macro.
package dof_operand_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // R0 always reads as zero and is never a real forwarding target.
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_EX   = 3'd1,
        SRC_WB   = 3'd2,
        SRC_RF   = 3'd3,
        SRC_IMM  = 3'd4
    } src_sel_e;

endpackage

// File: rtl/dof_operand_stage_fwd_mux.sv
// Per-operand source select: immediate, R0, EX forward, optional WB bypass, register file.
// WB bypass ports and path exist only when DOF_WB_BYPASS_EN is defined.
module dof_operand_stage_fwd_mux
    import dof_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_valid,
    input  logic              ex_rw,
    input  logic              ex_mr,
    input  logic [ADDR_W-1:0] ex_da,
    input  logic [DATA_W-1:0] ex_result,
`ifdef DOF_WB_BYPASS_EN
    input  logic              wb_rw,
    input  logic [ADDR_W-1:0] wb_da,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic [DATA_W-1:0] operand
);

    src_sel_e sel;

    // A load in EX has no result yet, so it is never a forwarding source.
    always_comb begin
        sel = SRC_RF;
        if (use_imm) begin
            sel = SRC_IMM;
        end else if (addr == ADDR_W'(REG_ZERO)) begin
            sel = SRC_ZERO;
        end else if (ex_valid && ex_rw && !ex_mr && (ex_da == addr)) begin
            sel = SRC_EX;
        end
`ifdef DOF_WB_BYPASS_EN
        else if (wb_rw && (wb_da == addr)) begin
            sel = SRC_WB;
        end
`endif
    end

    always_comb begin
        operand = '0;
        case (sel)
            SRC_ZERO: operand = '0;
            SRC_EX:   operand = ex_result;
`ifdef DOF_WB_BYPASS_EN
            SRC_WB:   operand = wb_data;
`endif
            SRC_RF:   operand = rf_data;
            SRC_IMM:  operand = imm;
            default:  operand = '0;
        endcase
    end

endmodule

// File: rtl/dof_operand_stage.sv
// DOF stage: register-file read, EX/WB forwarding, hazard stall and DOF/EX pipeline register.
// Define DOF_WB_BYPASS_EN to forward WB data instead of stalling on a WB match.
module dof_operand_stage
    import dof_operand_stage_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_aa,
    input  logic [ADDR_W-1:0]      in_ba,
    input  logic [ADDR_W-1:0]      in_da,
    input  logic                   in_rw,
    input  logic                   in_mr,
    input  logic                   in_use_imm,
    input  logic [DATA_W-1:0]      in_imm,
    output logic [ADDR_W-1:0]      rf_a_addr,
    output logic [ADDR_W-1:0]      rf_b_addr,
    input  logic [DATA_W-1:0]      rf_a_data,
    input  logic [DATA_W-1:0]      rf_b_data,
    input  logic                   ex_valid,
    input  logic                   ex_rw,
    input  logic                   ex_mr,
    input  logic [ADDR_W-1:0]      ex_da,
    input  logic [DATA_W-1:0]      ex_result,
    input  logic                   wb_rw,
    input  logic [ADDR_W-1:0]      wb_da,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_a,
    output logic [DATA_W-1:0]      out_b,
    output logic [ADDR_W-1:0]      out_da,
    output logic                   out_rw,
    output logic                   out_mr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic              hazard_ld;
    logic              hazard_wb;
    logic              slot_free;
    logic              accept;
    logic              b_used;
    logic [DATA_W-1:0] a_operand;
    logic [DATA_W-1:0] b_operand;

    assign rf_a_addr = in_aa;
    assign rf_b_addr = in_ba;
    assign b_used    = !in_use_imm;

    assign hazard_ld = in_valid && ex_valid && ex_rw && ex_mr && (ex_da != ADDR_W'(REG_ZERO))
                       && ((ex_da == in_aa) || (b_used && (ex_da == in_ba)));

`ifdef DOF_WB_BYPASS_EN
    assign hazard_wb = 1'b0;
`else
    // The register file commits WB on the same edge, so a reader waits one cycle.
    assign hazard_wb = in_valid && wb_rw && (wb_da != ADDR_W'(REG_ZERO))
                       && ((wb_da == in_aa) || (b_used && (wb_da == in_ba)));

    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready may depend on in_valid (hazards), out_valid never depends on out_ready.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = rst && !hazard_ld && !hazard_wb && slot_free;
    assign accept    = in_valid && in_ready;

    dof_operand_stage_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_a (
        .addr      (in_aa),
        .use_imm   (1'b0),
        .imm       ('0),
        .rf_data   (rf_a_data),
        .ex_valid  (ex_valid),
        .ex_rw     (ex_rw),
        .ex_mr     (ex_mr),
        .ex_da     (ex_da),
        .ex_result (ex_result),
`ifdef DOF_WB_BYPASS_EN
        .wb_rw     (wb_rw),
        .wb_da     (wb_da),
        .wb_data   (wb_data),
`endif
        .operand   (a_operand)
    );

    dof_operand_stage_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_b (
        .addr      (in_ba),
        .use_imm   (in_use_imm),
        .imm       (in_imm),
        .rf_data   (rf_b_data),
        .ex_valid  (ex_valid),
        .ex_rw     (ex_rw),
        .ex_mr     (ex_mr),
        .ex_da     (ex_da),
        .ex_result (ex_result),
`ifdef DOF_WB_BYPASS_EN
        .wb_rw     (wb_rw),
        .wb_da     (wb_da),
        .wb_data   (wb_data),
`endif
        .operand   (b_operand)
    );

    // Flush wins over capture, hold and bubble; payload is left untouched when not capturing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_da    <= '0;
            out_rw    <= 1'b0;
            out_mr    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_a     <= a_operand;
                out_b     <= b_operand;
                out_da    <= in_da;
                out_rw    <= in_rw;
                out_mr    <= in_mr;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end

            if (in_valid && !in_ready && !flush && (stall_cnt != STALL_MAX)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dof_operand_stage.sv
// Directed bench for dof_operand_stage; expectations follow DOF_WB_BYPASS_EN when defined.
module tb_dof_operand_stage;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int STALL_W   = 3;
    localparam int STALL_MAX = 7;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_aa;
    logic [ADDR_W-1:0] in_ba;
    logic [ADDR_W-1:0] in_da;
    logic              in_rw;
    logic              in_mr;
    logic              in_use_imm;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] rf_a_addr;
    logic [ADDR_W-1:0] rf_b_addr;
    logic [DATA_W-1:0] rf_a_data;
    logic [DATA_W-1:0] rf_b_data;
    logic              ex_valid;
    logic              ex_rw;
    logic              ex_mr;
    logic [ADDR_W-1:0] ex_da;
    logic [DATA_W-1:0] ex_result;
    logic              wb_rw;
    logic [ADDR_W-1:0] wb_da;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [ADDR_W-1:0] out_da;
    logic              out_rw;
    logic              out_mr;
    logic [STALL_W-1:0] stall_cnt;

    int total;
    int bad;
    int exp_stall;

    dof_operand_stage #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STALL_CNT_W (STALL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aa      (in_aa),
        .in_ba      (in_ba),
        .in_da      (in_da),
        .in_rw      (in_rw),
        .in_mr      (in_mr),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .rf_a_addr  (rf_a_addr),
        .rf_b_addr  (rf_b_addr),
        .rf_a_data  (rf_a_data),
        .rf_b_data  (rf_b_data),
        .ex_valid   (ex_valid),
        .ex_rw      (ex_rw),
        .ex_mr      (ex_mr),
        .ex_da      (ex_da),
        .ex_result  (ex_result),
        .wb_rw      (wb_rw),
        .wb_da      (wb_da),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_da     (out_da),
        .out_rw     (out_rw),
        .out_mr     (out_mr),
        .stall_cnt  (stall_cnt)
    );

    // Clock and reset-time register file model (WB commits on the rising edge).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] rf_init(input int i);
        case (i)
            0:       rf_init = 32'h0000_0BAD;
            3:       rf_init = 32'h0000_0011;
            7:       rf_init = 32'h0000_0077;
            default: rf_init = 32'h1000_0000 + DATA_W'(i);
        endcase
    endfunction

    logic [DATA_W-1:0] rf [32];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (wb_rw && (wb_da != '0)) begin
            rf[wb_da] <= wb_data;
        end
    end

    assign rf_a_data = rf[rf_a_addr];
    assign rf_b_data = rf[rf_b_addr];

    // Driver and checking helpers.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_stall();
        if (exp_stall < STALL_MAX) exp_stall++;
    endtask

    initial begin
        total = 0; bad = 0; exp_stall = 0;
        rst = 1'b0; in_valid = 1'b1; in_aa = 5'd1; in_ba = 5'd2; in_da = '0;
        in_rw = 1'b0; in_mr = 1'b0; in_use_imm = 1'b0; in_imm = '0;
        ex_valid = 1'b0; ex_rw = 1'b0; ex_mr = 1'b0; ex_da = '0; ex_result = '0;
        wb_rw = 1'b0; wb_da = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset held two cycles with a pending instruction
        repeat (2) begin
            step();
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_stall", stall_cnt, 0);
            check("rst_out_a", out_a, 0);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #1 check("idle_in_ready", in_ready, 1);

        // EX forward to A
        in_valid = 1'b1; in_aa = 5'd3; in_ba = 5'd4; in_da = 5'd9; in_rw = 1'b1;
        ex_valid = 1'b1; ex_rw = 1'b1; ex_mr = 1'b0; ex_da = 5'd3; ex_result = 32'h0000_00AA;
        #1 check("exfwd_in_ready", in_ready, 1);
        step();
        check("exfwd_out_valid", out_valid, 1);
        check("exfwd_out_a", out_a, 32'h0000_00AA);
        check("exfwd_out_b", out_b, 32'h1000_0004);
        check("exfwd_out_da", out_da, 9);
        check("exfwd_out_rw", out_rw, 1);

        // Load-use on B: one bubble, then capture once EX clears
        @(negedge clk);
        in_aa = 5'd1; in_ba = 5'd5; in_da = 5'd10; in_mr = 1'b1;
        ex_mr = 1'b1; ex_da = 5'd5;
        #1 check("ldu_in_ready", in_ready, 0);
        step(); bump_stall();
        check("ldu_bubble", out_valid, 0);
        check("ldu_stall", stall_cnt, exp_stall);
        @(negedge clk);
        ex_valid = 1'b0;
        #1 check("ldu_clear_ready", in_ready, 1);
        step();
        check("ldu_out_valid", out_valid, 1);
        check("ldu_out_a", out_a, 32'h1000_0001);
        check("ldu_out_b", out_b, 32'h1000_0005);
        check("ldu_out_mr", out_mr, 1);
        check("ldu_stall_hold", stall_cnt, exp_stall);

        // WB match on A
        @(negedge clk);
        in_aa = 5'd7; in_ba = 5'd2; in_da = 5'd11; in_mr = 1'b0;
        wb_rw = 1'b1; wb_da = 5'd7; wb_data = 32'hDEAD_BEEF;
`ifdef DOF_WB_BYPASS_EN
        #1 check("wb_in_ready", in_ready, 1);
        step();
        check("wb_out_valid", out_valid, 1);
        check("wb_out_a", out_a, 32'hDEAD_BEEF);
        check("wb_stall", stall_cnt, exp_stall);
`else
        #1 check("wb_in_ready", in_ready, 0);
        step(); bump_stall();
        check("wb_bubble", out_valid, 0);
        check("wb_stall", stall_cnt, exp_stall);
        @(negedge clk);
        wb_rw = 1'b0;
        #1 check("wb_clear_ready", in_ready, 1);
        step();
        check("wb_out_valid", out_valid, 1);
        check("wb_out_a", out_a, 32'hDEAD_BEEF);
        check("wb_out_b", out_b, 32'h1000_0002);
`endif

        // R0 stays zero even with EX writing R0
        @(negedge clk);
        wb_rw = 1'b0; in_aa = 5'd0; in_ba = 5'd3; in_da = 5'd1;
        ex_valid = 1'b1; ex_rw = 1'b1; ex_mr = 1'b0; ex_da = 5'd0; ex_result = 32'h0000_0055;
        #1 check("r0_in_ready", in_ready, 1);
        step();
        check("r0_out_a", out_a, 0);
        check("r0_out_b", out_b, 32'h0000_0011);

        // Immediate B hides a load-use on in_ba
        @(negedge clk);
        in_aa = 5'd1; in_ba = 5'd6; in_use_imm = 1'b1; in_imm = 32'h0000_0010;
        ex_mr = 1'b1; ex_da = 5'd6;
        #1 check("imm_in_ready", in_ready, 1);
        step();
        check("imm_out_b", out_b, 32'h0000_0010);
        check("imm_out_a", out_a, 32'h1000_0001);
        check("imm_stall", stall_cnt, exp_stall);

        // Backpressure for 3 cycles: outputs hold, stall counts
        @(negedge clk);
        ex_valid = 1'b0; in_use_imm = 1'b0; in_aa = 5'd2; in_ba = 5'd4; in_da = 5'd12;
        out_ready = 1'b0;
        #1 check("bp_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step(); bump_stall();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_a", out_a, 32'h1000_0001);
            check("bp_out_b", out_b, 32'h0000_0010);
            check("bp_stall", stall_cnt, exp_stall);
        end

        // Flush during hold: drop the instruction, no stall count
        @(negedge clk);
        flush = 1'b1;
        step();
        check("flush_out_valid", out_valid, 0);
        check("flush_stall", stall_cnt, exp_stall);

        // Flush beats capture
        @(negedge clk);
        #1 check("flushcap_in_ready", in_ready, 1);
        step();
        check("flushcap_out_valid", out_valid, 0);
        check("flushcap_stall", stall_cnt, exp_stall);

        // Capture, then stall long enough to saturate the counter
        @(negedge clk);
        flush = 1'b0;
        step();
        check("cap_out_valid", out_valid, 1);
        check("cap_out_a", out_a, 32'h1000_0002);
        check("cap_out_b", out_b, 32'h1000_0004);
        check("cap_out_da", out_da, 12);
        for (int k = 0; k < 5; k++) begin
            step(); bump_stall();
            check("sat_stall", stall_cnt, exp_stall);
            check("sat_out_a", out_a, 32'h1000_0002);
        end
        check("sat_max", stall_cnt, STALL_MAX);

        // Drain
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        check("drain_out_valid", out_valid, 0);
        check("drain_stall", stall_cnt, STALL_MAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
